// File: rtl/rx_arp_pkg.sv
// Shared constants, FSM state type and helpers for the receive-side ARP parser.
//   - Ethernet/ARP field constants compared against the incoming word stream.
//   - Word-index constants for the 21-word ARP frame map.
//   - arp_state_e: parser FSM states.
//   - mac_word(): selects one 16-bit word of a 48-bit MAC, most significant first.
package rx_arp_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IP  = 16'h0800;
  localparam logic [15:0] ARP_HLEN_PLEN = 16'h0604;
  localparam logic [15:0] ARP_OP_REQ    = 16'd1;
  localparam logic [15:0] ARP_OP_RPL    = 16'd2;

  localparam int unsigned ARP_WORDS = 21;
  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  // Last ARP word index, and the saturation value used while skipping padding/FCS.
  localparam logic [4:0] W_LAST = 5'(ARP_WORDS - 1);
  localparam logic [4:0] W_SAT  = 5'(ARP_WORDS);

  // Word indices inside the frame.
  localparam logic [4:0] W_DST0  = 5'd0;
  localparam logic [4:0] W_DST1  = 5'd1;
  localparam logic [4:0] W_DST2  = 5'd2;
  localparam logic [4:0] W_ETYPE = 5'd6;
  localparam logic [4:0] W_HTYPE = 5'd7;
  localparam logic [4:0] W_PTYPE = 5'd8;
  localparam logic [4:0] W_HLPL  = 5'd9;
  localparam logic [4:0] W_OPER  = 5'd10;
  localparam logic [4:0] W_SHA0  = 5'd11;
  localparam logic [4:0] W_SHA1  = 5'd12;
  localparam logic [4:0] W_SHA2  = 5'd13;
  localparam logic [4:0] W_SPA0  = 5'd14;
  localparam logic [4:0] W_SPA1  = 5'd15;
  localparam logic [4:0] W_TPA0  = 5'd19;
  localparam logic [4:0] W_TPA1  = 5'd20;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StSkip,
    StEval
  } arp_state_e;

  function automatic logic [15:0] mac_word(input logic [47:0] mac, input logic [1:0] k);
    case (k)
      2'd0:    return mac[47:32];
      2'd1:    return mac[31:16];
      default: return mac[15:0];
    endcase
  endfunction

endpackage

// File: rtl/rx_arp.sv
// Receive-side ARP parser.
// Consumes Ethernet frames as a 16-bit big-endian word stream, checks the Ethernet header and
// ARP body on the fly against local configuration, and reports:
//   - ARP requests for our IP (cfg_sip): ack_en pulse, requester MAC on ack_mac_d.
//   - ARP replies from the peer (cfg_dip): peer_mac_vld pulse, peer MAC on peer_mac.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_arp_data/vld/sop/eop/mty  input stream (no backpressure; mty is not needed for parsing)
//   cfg_mac_s, cfg_sip, cfg_dip  local MAC, local IP, peer IP
//   ack_en, ack_mac_d             request detected / sender MAC of last accepted request
//   peer_mac_vld, peer_mac        reply detected / sender MAC of last accepted reply
// Outputs are registered: a pulse lands two clocks after the vld&eop cycle.
module rx_arp
  import rx_arp_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MAC_ADDR_W = 48,
  parameter int unsigned IP_ADDR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     rx_arp_data,
  input  logic                  rx_arp_vld,
  input  logic                  rx_arp_sop,
  input  logic                  rx_arp_eop,
  input  logic                  rx_arp_mty,
  input  logic [MAC_ADDR_W-1:0] cfg_mac_s,
  input  logic [IP_ADDR_W-1:0]  cfg_sip,
  input  logic [IP_ADDR_W-1:0]  cfg_dip,
  output logic                  ack_en,
  output logic [MAC_ADDR_W-1:0] ack_mac_d,
  output logic                  peer_mac_vld,
  output logic [MAC_ADDR_W-1:0] peer_mac
);

  // The ARP payload is always whole words, so the empty-byte flag carries no information here.
  logic unused_mty;
  assign unused_mty = rx_arp_mty;

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  arp_state_e state_q, state_d;
  logic [4:0] w_q, w_d;

  // Sticky per-frame check flags.
  logic dst_uc_q, dst_uc_d;   // dst MAC matches cfg_mac_s so far
  logic dst_bc_q, dst_bc_d;   // dst MAC is broadcast so far
  logic hdr_q, hdr_d;         // ethertype/htype/ptype/hlen-plen all correct so far
  logic op_req_q, op_req_d;
  logic op_rpl_q, op_rpl_d;
  logic tip_q, tip_d;         // target IP matches cfg_sip so far

  // The only raw fields kept: sender MAC and sender IP.
  logic [MAC_ADDR_W-1:0] smac_q, smac_d;
  logic [IP_ADDR_W-1:0]  sip_q, sip_d;

  logic                  ack_en_q, peer_vld_q;
  logic [MAC_ADDR_W-1:0] ack_mac_q, peer_mac_q;

  // Word consumed this cycle and its index in the frame.
  logic       consume;
  logic [4:0] widx;
  logic       restart;

  // A sop aborts whatever frame is in progress; EVAL is a single decision cycle and ignores it.
  assign restart = rx_arp_vld && rx_arp_sop && (state_q != StEval);

  // ---------------------------------------------------------------------------------------------
  // FSM and word counter
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    consume = 1'b0;
    widx    = w_q;

    if (restart) begin
      if (rx_arp_eop) begin
        // Single-word frame: runt.
        state_d = StIdle;
        w_d     = 5'd0;
      end else begin
        consume = 1'b1;
        widx    = W_DST0;
        w_d     = 5'd1;
        state_d = StRecv;
      end
    end else begin
      case (state_q)
        StIdle: begin
          w_d = 5'd0;
        end

        StRecv: begin
          if (rx_arp_vld) begin
            consume = 1'b1;
            if (w_q == W_LAST) begin
              w_d     = W_SAT;
              state_d = rx_arp_eop ? StEval : StSkip;
            end else if (rx_arp_eop) begin
              // Frame ended before the ARP body was complete.
              state_d = StIdle;
              w_d     = 5'd0;
            end else begin
              w_d = w_q + 5'd1;
            end
          end
        end

        StSkip: begin
          // Padding and FCS; the counter stays saturated.
          if (rx_arp_vld && rx_arp_eop) begin
            state_d = StEval;
          end
        end

        StEval: begin
          state_d = StIdle;
          w_d     = 5'd0;
        end

        default: begin
          state_d = StIdle;
          w_d     = 5'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // On-the-fly field checks and sender field capture
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    dst_uc_d = dst_uc_q;
    dst_bc_d = dst_bc_q;
    hdr_d    = hdr_q;
    op_req_d = op_req_q;
    op_rpl_d = op_rpl_q;
    tip_d    = tip_q;
    smac_d   = smac_q;
    sip_d    = sip_q;

    if (consume) begin
      case (widx)
        W_DST0: begin
          // First word of a frame re-arms every flag.
          dst_uc_d = (rx_arp_data == mac_word(cfg_mac_s, 2'd0));
          dst_bc_d = (rx_arp_data == mac_word(MAC_BCAST, 2'd0));
          hdr_d    = 1'b1;
          op_req_d = 1'b0;
          op_rpl_d = 1'b0;
          tip_d    = 1'b0;
        end
        W_DST1: begin
          dst_uc_d = dst_uc_q & (rx_arp_data == mac_word(cfg_mac_s, 2'd1));
          dst_bc_d = dst_bc_q & (rx_arp_data == mac_word(MAC_BCAST, 2'd1));
        end
        W_DST2: begin
          dst_uc_d = dst_uc_q & (rx_arp_data == mac_word(cfg_mac_s, 2'd2));
          dst_bc_d = dst_bc_q & (rx_arp_data == mac_word(MAC_BCAST, 2'd2));
        end
        W_ETYPE: hdr_d = hdr_q & (rx_arp_data == ETH_TYPE_ARP);
        W_HTYPE: hdr_d = hdr_q & (rx_arp_data == ARP_HTYPE_ETH);
        W_PTYPE: hdr_d = hdr_q & (rx_arp_data == ARP_PTYPE_IP);
        W_HLPL:  hdr_d = hdr_q & (rx_arp_data == ARP_HLEN_PLEN);
        W_OPER: begin
          op_req_d = (rx_arp_data == ARP_OP_REQ);
          op_rpl_d = (rx_arp_data == ARP_OP_RPL);
        end
        W_SHA0: smac_d[47:32] = rx_arp_data;
        W_SHA1: smac_d[31:16] = rx_arp_data;
        W_SHA2: smac_d[15:0]  = rx_arp_data;
        W_SPA0: sip_d[31:16]  = rx_arp_data;
        W_SPA1: sip_d[15:0]   = rx_arp_data;
        W_TPA0: tip_d = (rx_arp_data == cfg_sip[31:16]);
        W_TPA1: tip_d = tip_q & (rx_arp_data == cfg_sip[15:0]);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Decision in EVAL
  // ---------------------------------------------------------------------------------------------
  logic base_ok;
  logic req_hit;
  logic rpl_hit;

  assign base_ok = (dst_uc_q | dst_bc_q) & hdr_q & tip_q;
  assign req_hit = (state_q == StEval) & base_ok & op_req_q;
  assign rpl_hit = (state_q == StEval) & base_ok & op_rpl_q & (sip_q == cfg_dip);

  // ---------------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      w_q      <= 5'd0;
      dst_uc_q <= 1'b0;
      dst_bc_q <= 1'b0;
      hdr_q    <= 1'b0;
      op_req_q <= 1'b0;
      op_rpl_q <= 1'b0;
      tip_q    <= 1'b0;
      smac_q   <= '0;
      sip_q    <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      dst_uc_q <= dst_uc_d;
      dst_bc_q <= dst_bc_d;
      hdr_q    <= hdr_d;
      op_req_q <= op_req_d;
      op_rpl_q <= op_rpl_d;
      tip_q    <= tip_d;
      smac_q   <= smac_d;
      sip_q    <= sip_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_en_q   <= 1'b0;
      peer_vld_q <= 1'b0;
      ack_mac_q  <= '0;
      peer_mac_q <= '0;
    end else begin
      ack_en_q   <= req_hit;
      peer_vld_q <= rpl_hit;
      if (req_hit) begin
        ack_mac_q <= smac_q;
      end
      if (rpl_hit) begin
        peer_mac_q <= smac_q;
      end
    end
  end

  assign ack_en       = ack_en_q;
  assign ack_mac_d    = ack_mac_q;
  assign peer_mac_vld = peer_vld_q;
  assign peer_mac     = peer_mac_q;

endmodule
